// File: rtl/vpu_inst_dispatch.sv
// vpu_inst_dispatch: instruction FIFO plus issue/wait FSM feeding the VPU sequencer
module vpu_inst_dispatch #(
    parameter int DEPTH   = 8,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic                     flush,
    output logic [31:0]              inst,
    output logic                     mem_rdy,
    output logic                     mem_read_en,
    output logic                     mem_write_en,
    input  logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         retired,
    output logic                     err_timeout,
    output logic                     err_illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [OP_W:0] NOPS = (OP_W + 1)'(NUM_OPS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t          state_q;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   wd_q;
    logic [31:0]     head;
    logic            empty, illegal, pop, push;

    assign head       = mem_q[rd_q];
    assign empty      = cnt_q == '0;
    assign illegal    = {1'b0, head[OP_W-1:0]} >= NOPS;
    // Head leaves the FIFO whenever IDLE sees it, issued or discarded
    assign pop        = state_q == IDLE && !empty && !flush;
    // A full FIFO still accepts when the head is leaving the same cycle
    assign in_ready   = !flush && (cnt_q != CW'(DEPTH) || pop);
    assign push       = in_valid && in_ready;
    assign cnt_d      = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    assign busy       = !empty || state_q != IDLE;
    assign fifo_count = cnt_q;

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_q] <= in_inst;
    end

    // FIFO pointers and occupancy; flush returns everything to empty
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= flush ? '0 : wr_q + AW'(push);
            rd_q  <= flush ? '0 : rd_q + AW'(pop);
            cnt_q <= cnt_d;
        end
    end

    // Issue FSM with registered sequencer outputs, watchdog and status
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            inst         <= '0;
            mem_rdy      <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            wd_q         <= '0;
            retired      <= '0;
            err_timeout  <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            mem_rdy <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop && illegal) err_illegal <= 1'b1;
                    if (pop && !illegal) begin
                        inst    <= head;
                        mem_rdy <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_read_en  <= 1'b1;
                    mem_write_en <= 1'b1;
                    wd_q         <= '0;
                    state_q      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done || wd_q == WW'(TIMEOUT - 1)) begin
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        state_q      <= IDLE;
                    end
                    if (done) retired <= retired + CNT_W'(1);
                    else if (wd_q == WW'(TIMEOUT - 1)) err_timeout <= 1'b1;
                    else wd_q <= wd_q + WW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vpu_inst_dispatch.sv
// tb_vpu_inst_dispatch: directed checks of issue, backpressure, filtering, watchdog, flush and reset
module tb_vpu_inst_dispatch;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, done;
    logic [31:0] in_inst;
    logic        in_ready, mem_rdy, mem_read_en, mem_write_en, busy, err_timeout, err_illegal;
    logic [31:0] inst;
    logic [3:0]  fifo_count;
    logic [15:0] retired;
    logic        s_in_ready, s_mem_rdy, s_mem_read_en, s_mem_write_en, s_busy, s_err_timeout, s_err_illegal;
    logic [31:0] s_inst;
    logic [3:0]  s_fifo_count;
    logic [3:0]  s_retired;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulses;

    always #5 clk = ~clk;

    vpu_inst_dispatch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .flush(flush), .inst(inst), .mem_rdy(mem_rdy), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .done(done), .busy(busy), .fifo_count(fifo_count),
        .retired(retired), .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    // Narrow retired counter so the wrap can be reached in a short run
    vpu_inst_dispatch #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_inst(in_inst),
        .flush(flush), .inst(s_inst), .mem_rdy(s_mem_rdy), .mem_read_en(s_mem_read_en),
        .mem_write_en(s_mem_write_en), .done(done), .busy(s_busy), .fifo_count(s_fifo_count),
        .retired(s_retired), .err_timeout(s_err_timeout), .err_illegal(s_err_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0000 + 32'(i << 8) + 32'(i % 8);
    endfunction

    // Wait (bounded) for an issue strobe, check the word, then complete it
    task automatic issue_done(input string tag, input logic [31:0] exp);
        int k = 0;
        while (!mem_rdy && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rdy"}, mem_rdy, 1);
        chk({tag, "_inst"}, inst, exp);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; done = 1'b0;
        tick();
        tick();
        chk("rst_inst", inst, 0);
        chk("rst_mem_rdy", mem_rdy, 0);
        chk("rst_rw", {mem_read_en, mem_write_en}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_retired", retired, 0);
        chk("rst_errs", {err_timeout, err_illegal}, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Single instruction latency
        in_valid = 1'b1; in_inst = 32'h0000_1061;
        tick();
        in_valid = 1'b0;
        chk("t1_count", fifo_count, 1);
        chk("t1_no_rdy_yet", mem_rdy, 0);
        tick();
        chk("t1_mem_rdy", mem_rdy, 1);
        chk("t1_inst", inst, 32'h0000_1061);
        chk("t1_count_popped", fifo_count, 0);
        tick();
        chk("t1_rdy_one_cycle", mem_rdy, 0);
        chk("t1_rw_en", {mem_read_en, mem_write_en}, 2'b11);
        chk("t1_inst_held", inst, 32'h0000_1061);
        repeat (3) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_retired", retired, 1);
        chk("t1_busy", busy, 0);
        chk("t1_rw_off", {mem_read_en, mem_write_en}, 0);
        chk("t1_inst_kept", inst, 32'h0000_1061);

        // Fill the FIFO behind a stalled instruction
        in_valid = 1'b1; in_inst = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t2_wait", mem_read_en, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_inst = w(i);
            tick();
        end
        chk("t2_full_count", fifo_count, 8);
        chk("t2_full_ready", in_ready, 0);
        in_inst = w(8);
        tick();
        chk("t2_full_hold", fifo_count, 8);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_retired_a", retired, 2);
        chk("t2_ready_with_pop", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_count_push_pop", fifo_count, 8);
        for (int i = 0; i < 9; i++) issue_done($sformatf("t2_w%0d", i), w(i));
        chk("t2_retired", retired, 11);
        chk("t2_idle", busy, 0);

        // Illegal opcode filtering
        in_valid = 1'b1; in_inst = 32'h0000_0009;
        tick();
        in_inst = 32'h0000_0202;
        tick();
        in_valid = 1'b0;
        chk("t3_err_illegal", err_illegal, 1);
        chk("t3_no_issue", mem_rdy, 0);
        chk("t3_count", fifo_count, 1);
        issue_done("t3_op2", 32'h0000_0202);
        chk("t3_retired", retired, 12);
        in_valid = 1'b1; in_inst = 32'h0000_0008;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_op8_dropped", fifo_count, 0);
        chk("t3_op8_busy", busy, 0);
        tick();
        chk("t3_op8_no_issue", mem_rdy, 0);
        chk("t3_op8_retired", retired, 12);
        chk("t3_inst_kept", inst, 32'h0000_0202);

        // done on the final watchdog cycle wins
        in_valid = 1'b1; in_inst = 32'h0000_0505;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_issue", mem_rdy, 1);
        tick();
        repeat (63) tick();
        chk("t4_still_wait", mem_read_en, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t4_no_timeout", err_timeout, 0);
        chk("t4_retired", retired, 13);
        chk("t4_idle", mem_read_en, 0);

        // Watchdog timeout with a second instruction queued
        in_valid = 1'b1; in_inst = 32'h0000_0303;
        tick();
        in_inst = 32'h0000_0404;
        tick();
        in_valid = 1'b0;
        chk("t5_issue", inst, 32'h0000_0303);
        tick();
        repeat (63) tick();
        chk("t5_wait_63", mem_read_en, 1);
        chk("t5_no_err_yet", err_timeout, 0);
        tick();
        chk("t5_err_timeout", err_timeout, 1);
        chk("t5_idle", mem_read_en, 0);
        chk("t5_retired", retired, 13);
        chk("t5_queued", fifo_count, 1);
        issue_done("t5_next", 32'h0000_0404);
        chk("t5_retired_next", retired, 14);
        chk("t5_err_sticky", err_timeout, 1);

        // Flush while an instruction is in flight
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_inst = 32'hF000_0000 + 32'(i);
            tick();
        end
        chk("t6_count", fifo_count, 4);
        chk("t6_wait", mem_read_en, 1);
        in_inst = 32'hF000_0077;
        flush = 1'b1;
        #1;
        chk("t6_ready_in_flush", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("t6_flushed", fifo_count, 0);
        chk("t6_inflight", mem_read_en, 1);
        chk("t6_inst_held", inst, 32'hF000_0000);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t6_retired", retired, 15);
        chk("t6_s_retired", s_retired, 4'hF);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pulses += int'(mem_rdy);
            tick();
        end
        chk("t6_no_more_issue", pulses, 0);
        chk("t6_busy", busy, 0);

        // Retired counter wrap on the narrow instance
        in_valid = 1'b1; in_inst = 32'h0000_0606;
        tick();
        in_valid = 1'b0;
        issue_done("t7_g", 32'h0000_0606);
        chk("t7_retired", retired, 16);
        chk("t7_s_wrap", s_retired, 4'h0);

        // Reset in the middle of WAIT_DONE
        in_valid = 1'b1; in_inst = 32'h0000_0707;
        tick();
        in_inst = 32'h0000_0101;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t8_wait", mem_read_en, 1);
        chk("t8_queued", fifo_count, 1);
        rst = 1'b0;
        tick();
        chk("t8_inst", inst, 0);
        chk("t8_mem_rdy", mem_rdy, 0);
        chk("t8_rw", {mem_read_en, mem_write_en}, 0);
        chk("t8_retired", retired, 0);
        chk("t8_errs", {err_timeout, err_illegal}, 0);
        chk("t8_count", fifo_count, 0);
        chk("t8_busy", busy, 0);
        rst = 1'b1;
        tick();
        chk("t8_no_residual_rdy", mem_rdy, 0);
        chk("t8_ready", in_ready, 1);
        tick();
        chk("t8_still_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
